// File: rtl/val2_pkg.sv
// Shared constants and enums for the Val2 operand sequencer and its one-step shifter.
package val2_pkg;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } shift_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;
endpackage

// File: rtl/val2_step_unit.sv
// One combinational bit-step of the Val2 shifter: a 1-bit LSL/LSR/ASR/ROR, or a 2-bit ROR for immediates.
// Optional VAL2_CARRY_EN adds the carry-out of the step.
module val2_step_unit
  import val2_pkg::*;
(
  input  logic [DATA_W-1:0] acc_i,
  input  shift_mode_e       mode_i,
  input  logic              imm_step_i,
`ifdef VAL2_CARRY_EN
  output logic              carry_o,
`endif
  output logic [DATA_W-1:0] acc_o
);

  logic [DATA_W-1:0] nxt;
  logic              cy;

  always_comb begin
    nxt = acc_i;
    cy  = 1'b0;
    if (imm_step_i) begin
      // immediate carry is the new bit31 after each rotate-by-2
      nxt = {acc_i[1:0], acc_i[DATA_W-1:2]};
      cy  = acc_i[1];
    end else begin
      unique case (mode_i)
        LSL: begin nxt = {acc_i[DATA_W-2:0], 1'b0};        cy = acc_i[DATA_W-1]; end
        LSR: begin nxt = {1'b0, acc_i[DATA_W-1:1]};        cy = acc_i[0]; end
        ASR: begin nxt = {acc_i[DATA_W-1], acc_i[DATA_W-1:1]}; cy = acc_i[0]; end
        ROR: begin nxt = {acc_i[0], acc_i[DATA_W-1:1]};    cy = acc_i[0]; end
        default: begin nxt = acc_i; cy = 1'b0; end
      endcase
    end
  end

  assign acc_o = nxt;
`ifdef VAL2_CARRY_EN
  assign carry_o = cy;
`endif

endmodule

// File: rtl/val2_shift_sequencer.sv
// Val2 operand generator, one shift step per cycle; done N+1 cycles after accepted start, starts ignored while busy.
// VAL2_CARRY_EN adds carry_in / shifter_carry ports.
module val2_shift_sequencer
  import val2_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              flush,
  input  logic              mem_rw,
  input  logic              imm,
  input  logic [11:0]       shift_operand,
  input  logic [DATA_W-1:0] val_rm,
`ifdef VAL2_CARRY_EN
  input  logic              carry_in,
  output logic              shifter_carry,
`endif
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] val2_out
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d, out_q, out_d;
  logic [DATA_W-1:0] ld_acc, step_acc;
  logic [CNT_W-1:0]  cnt_q, cnt_d, ld_cnt;
  shift_mode_e       mode_q, mode_d;
  logic              imm_step_q, imm_step_d, ld_imm_step;
  logic              accept, last_step;

  // operand and step count as they would be latched on accept
  always_comb begin
    ld_acc      = '0;
    ld_cnt      = '0;
    ld_imm_step = 1'b0;
    if (mem_rw) begin
      ld_acc = {{(DATA_W-12){1'b0}}, shift_operand};
    end else if (imm) begin
      ld_acc      = {{(DATA_W-8){1'b0}}, shift_operand[7:0]};
      ld_cnt      = CNT_W'(shift_operand[11:8]);
      ld_imm_step = 1'b1;
    end else if (!shift_operand[4]) begin
      ld_acc = val_rm;
      ld_cnt = CNT_W'(shift_operand[11:7]);
    end
  end

`ifdef VAL2_CARRY_EN
  logic step_carry;
`endif

  val2_step_unit u_step (
    .acc_i      (acc_q),
    .mode_i     (mode_q),
    .imm_step_i (imm_step_q),
`ifdef VAL2_CARRY_EN
    .carry_o    (step_carry),
`endif
    .acc_o      (step_acc)
  );

  assign ready     = (state_q != SHIFT);
  assign accept    = start && ready && !flush;
  assign busy      = (state_q == SHIFT) || accept;
  assign done      = (state_q == DONE);
  assign val2_out  = out_q;
  assign last_step = (state_q == SHIFT) && (cnt_q == CNT_W'(1));

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    imm_step_d = imm_step_q;
    out_d      = out_q;

    if (state_q == SHIFT) begin
      acc_d = step_acc;
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      if (last_step) begin
        state_d = DONE;
        out_d   = step_acc;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end

    if (accept) begin
      acc_d      = ld_acc;
      cnt_d      = ld_cnt;
      mode_d     = shift_mode_e'(shift_operand[6:5]);
      imm_step_d = ld_imm_step;
      if (ld_cnt == '0) begin
        state_d = DONE;
        out_d   = ld_acc;
      end else begin
        state_d = SHIFT;
      end
    end

    // abort keeps the previous result visible and never pulses done
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      out_d   = out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      mode_q     <= LSL;
      imm_step_q <= 1'b0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      imm_step_q <= imm_step_d;
      out_q      <= out_d;
    end
  end

`ifdef VAL2_CARRY_EN
  logic carry_q, carry_d, cout_q, cout_d;

  always_comb begin
    carry_d = carry_q;
    cout_d  = cout_q;
    if (state_q == SHIFT) begin
      carry_d = step_carry;
      if (last_step && !flush) cout_d = step_carry;
    end
    if (accept) begin
      carry_d = carry_in;
      if (ld_cnt == '0) cout_d = carry_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign shifter_carry = cout_q;
`endif

endmodule
